mmio_gpio_bank: RTL and testbench
=================================

// Module: mmio_gpio_bank
// PURPOSE
//  Parametrised memory-mapped GPIO bank; successor to the fixed 8-bit in/out port pair at 0x800.
//  Provides NPORTS ports of WIDTH bits, each with a per-bit direction register, a synchronised input,
//  sticky rising-edge capture and a maskable interrupt. Sits beside dmem on the CPU data bus.
//  Top level muxes rdata onto ReadData when hit=1.
// PARAMETERS
//  WIDTH      8        bits per port, 1..32
//  NPORTS     2        number of ports, 1..8
//  BASE_ADDR  32'h800  byte address of port 0 register 0; must be 32-byte aligned
// PORTS
//  clk      in   1              single clock; all state on rising edge
//  resetE   in   1              asynchronous, active-low reset
//  addr     in   32             byte address (ALUResult)
//  wdata    in   32             write data (WriteData); bits above WIDTH ignored
//  we       in   1              write strobe (MemWrite)
//  re       in   1              read qualifier (MemtoReg); gates hit only, no side effects
//  hit      out  1              combinational: addr decodes to a mapped register and (we|re)
//  rdata    out  32             combinational read data, zero-extended; 0 when hit=0
//  gpio_in  in   NPORTS*WIDTH   pin inputs, asynchronous; port p at [p*WIDTH +: WIDTH]
//  gpio_out out  NPORTS*WIDTH   DATA_OUT registers
//  gpio_oe  out  NPORTS*WIDTH   DIR registers; 1 = drive pin
//  irq      out  1              OR over all ports of (EDGE & IRQ_EN)
// BEHAVIOUR
//  Address map: port p at BASE_ADDR + 32*p.
//   +0x00  DATA_OUT  RW
//   +0x04  DIR       RW
//   +0x08  DATA_IN   RO  synchronised pin value, regardless of DIR
//   +0x0C  EDGE      W1C
//   +0x10  IRQ_EN    RW
//  Unmapped (hit=0, write ignored, rdata=0): +0x14..+0x1C, p>=NPORTS, addr[1:0]!=0.
//  Writes to DATA_IN are ignored but still give hit=1.
//  Reset (resetE=0, async): every register, every sync flop and irq = 0; gpio_out = gpio_oe = 0.
//   Applies immediately mid-operation; a write in the reset-release cycle is lost if resetE is still low at that edge.
//  Writes take effect at the rising edge where we=1 and hit=1. gpio_out/gpio_oe update on that edge (0-cycle register latency).
//  Reads are combinational, same cycle (single-cycle CPU); a read never changes state.
//  Input path: 2-flop synchroniser (s1, s2) plus a history flop s3.
//   A pin change is visible in DATA_IN 2 edges later.
//   Edge event per bit: s2 & ~s3 & ~DIR; EDGE sets on the 3rd edge after the pin change.
//  EDGE bit clears when written with 1; writing 0 leaves it unchanged.
//   Same-cycle set and W1C clear on one bit: set wins (bit stays 1).
//  DIR 1->0 transition does not fabricate an edge; s3 always tracks s2 regardless of DIR.
//  irq combinational from registers: |(EDGE_p & IRQ_EN_p) for all p. No pulse stretching; stays high until cleared.
//  Falling edges are not captured; pulses shorter than 1 clk may be missed (not required).
// STRUCTURE
//  gpio_pkg: localparams REG_DATA_OUT=3'd0, REG_DIR=3'd1, REG_DATA_IN=3'd2, REG_EDGE=3'd3, REG_IRQ_EN=3'd4,
//   PORT_STRIDE=32, NUM_REGS=5; function addr_decode(addr) returning {valid, port, reg}.
//  Sub-module gpio_sync_edge #(WIDTH): clk, resetE, pin, dir -> sync_val, rise (s1/s2/s3 + edge term).
//   One instance per port via generate.
//  Top: decode, register arrays [NPORTS], W1C logic, read mux, irq reduction.
// TESTING
//  1 Reset: drive resetE=0 mid-run with registers nonzero -> all outputs 0 immediately;
//    read DATA_OUT of port 1 after release -> 0.
//  2 Write 0x5A to 0x800, 0xF0 to 0x804 -> next edge gpio_out[7:0]=0x5A, gpio_oe[7:0]=0xF0;
//    read 0x800 -> rdata=0x0000005A, hit=1.
//  3 gpio_in[15:8] 0x00->0x81 at edge n -> 0x828 reads 0x81 from edge n+2;
//    0x82C reads 0x81 from edge n+3; irq stays 0 with IRQ_EN=0.
//  4 Set IRQ_EN(0x830)=0x01, EDGE=0x81 -> irq=1; write 0x80 to 0x82C -> EDGE=0x01, irq=1;
//    write 0x01 -> irq=0.
//  5 W1C 0x01 to 0x82C in the same cycle a new rise on bit0 is detected -> EDGE[0]=1 after the edge.
//  6 Access 0x814, 0x840 (NPORTS=2), 0x801 with we=1 -> hit=0, rdata=0, no register changes;
//    write to 0x808 -> hit=1, DATA_IN unchanged.

Source files
------------

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register map constants and address decode for the GPIO bank
package gpio_pkg;

    localparam logic [2:0] REG_DATA_OUT = 3'd0;
    localparam logic [2:0] REG_DIR      = 3'd1;
    localparam logic [2:0] REG_DATA_IN  = 3'd2;
    localparam logic [2:0] REG_EDGE     = 3'd3;
    localparam logic [2:0] REG_IRQ_EN   = 3'd4;

    localparam int PORT_STRIDE = 32;
    localparam int NUM_REGS    = 5;

    typedef struct packed {
        logic       valid;
        logic [2:0] port;
        logic [2:0] regsel;
    } gpio_dec_t;

    // Maps a byte address onto {valid, port, register}. Anything below the
    // base, misaligned, past the last port or in the reserved words of a
    // port's 32-byte window decodes as invalid.
    function automatic gpio_dec_t addr_decode(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned nports
    );
        logic [31:0] off;
        gpio_dec_t   d;
        off      = addr - base;
        d.port   = off[7:5];
        d.regsel = off[4:2];
        d.valid  = (addr >= base)
                && (off[1:0] == 2'b00)
                && ((off >> $clog2(PORT_STRIDE)) < nports)
                && (off[4:2] < 3'(NUM_REGS));
        return d;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - per-port pin synchroniser with rising-edge detect
//  clk, resetE  : clock, async active-low reset
//  pin          : raw asynchronous pin inputs
//  dir          : direction register, 1 = pin driven by us (edge masked)
//  sync_val     : pin value after two flops
//  rise         : one-cycle rising-edge event per input-direction bit
module gpio_sync_edge #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetE,
    input  logic [WIDTH-1:0] pin,
    input  logic [WIDTH-1:0] dir,
    output logic [WIDTH-1:0] sync_val,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;

    // s3 follows s2 unconditionally so flipping DIR back to input never
    // exposes a stale history value as a fake edge.
    always_ff @(posedge clk or negedge resetE) begin
        if (!resetE) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync_val = s2;
    assign rise     = s2 & ~s3 & ~dir;

endmodule

// File: rtl/mmio_gpio_bank.sv
// rtl/mmio_gpio_bank.sv - memory-mapped GPIO bank with edge capture and irq
//  clk, resetE       : clock, async active-low reset
//  addr, wdata, we   : CPU data bus address, write data, write strobe
//  re                : read qualifier, only gates hit
//  hit, rdata        : combinational decode hit and zero-extended read data
//  gpio_in           : asynchronous pin inputs, port p at [p*WIDTH +: WIDTH]
//  gpio_out, gpio_oe : DATA_OUT and DIR registers of every port
//  irq               : OR over ports of (EDGE & IRQ_EN)
module mmio_gpio_bank
    import gpio_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int          NPORTS    = 2,
    parameter logic [31:0] BASE_ADDR = 32'h800
) (
    input  logic                    clk,
    input  logic                    resetE,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    input  logic                    we,
    input  logic                    re,
    output logic                    hit,
    output logic [31:0]             rdata,
    input  logic [NPORTS*WIDTH-1:0] gpio_in,
    output logic [NPORTS*WIDTH-1:0] gpio_out,
    output logic [NPORTS*WIDTH-1:0] gpio_oe,
    output logic                    irq
);

    gpio_dec_t        dec;
    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] port_rd [NPORTS];
    logic [NPORTS-1:0] irq_vec;
    logic [WIDTH-1:0] rd_any;

    // wdata bits above WIDTH carry no meaning for this bank
    wire unused_wdata = ^wdata;

    assign dec   = addr_decode(addr, BASE_ADDR, NPORTS);
    assign hit   = dec.valid & (we | re);
    assign wr_en = hit & we;
    assign wd    = wdata[WIDTH-1:0];

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic [WIDTH-1:0] data_out_q;
        logic [WIDTH-1:0] dir_q;
        logic [WIDTH-1:0] edge_q;
        logic [WIDTH-1:0] irq_en_q;
        logic [WIDTH-1:0] sync_val;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] edge_clr;
        logic [WIDTH-1:0] port_val;
        logic             port_sel;

        gpio_sync_edge #(
            .WIDTH (WIDTH)
        ) u_sync (
            .clk      (clk),
            .resetE   (resetE),
            .pin      (gpio_in[p*WIDTH +: WIDTH]),
            .dir      (dir_q),
            .sync_val (sync_val),
            .rise     (rise)
        );

        assign port_sel = (dec.port == 3'(p));
        assign edge_clr = (wr_en && port_sel && dec.regsel == REG_EDGE) ? wd : '0;

        always_ff @(posedge clk or negedge resetE) begin
            if (!resetE) begin
                data_out_q <= '0;
                dir_q      <= '0;
                edge_q     <= '0;
                irq_en_q   <= '0;
            end else begin
                if (wr_en && port_sel) begin
                    case (dec.regsel)
                        REG_DATA_OUT: data_out_q <= wd;
                        REG_DIR:      dir_q      <= wd;
                        REG_IRQ_EN:   irq_en_q   <= wd;
                        default:      ;
                    endcase
                end
                // OR-ing the new event after the clear lets a coincident
                // rise survive a W1C of the same bit.
                edge_q <= (edge_q & ~edge_clr) | rise;
            end
        end

        always_comb begin
            port_val = '0;
            case (dec.regsel)
                REG_DATA_OUT: port_val = data_out_q;
                REG_DIR:      port_val = dir_q;
                REG_DATA_IN:  port_val = sync_val;
                REG_EDGE:     port_val = edge_q;
                REG_IRQ_EN:   port_val = irq_en_q;
                default:      port_val = '0;
            endcase
        end

        assign port_rd[p]                  = port_sel ? port_val : '0;
        assign irq_vec[p]                  = |(edge_q & irq_en_q);
        assign gpio_out[p*WIDTH +: WIDTH]  = data_out_q;
        assign gpio_oe[p*WIDTH +: WIDTH]   = dir_q;
    end

    always_comb begin
        rd_any = '0;
        for (int p = 0; p < NPORTS; p++) begin
            rd_any = rd_any | port_rd[p];
        end
        rdata = '0;
        if (hit) begin
            rdata[WIDTH-1:0] = rd_any;
        end
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// tb/tb_mmio_gpio_bank.sv - scoreboard bench for mmio_gpio_bank
module tb_mmio_gpio_bank;

    logic        clk = 1'b0;
    logic        resetE;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        hit;
    logic [31:0] rdata;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oe;
    logic        irq;

    logic        probe;
    logic        rstv;
    logic [15:0] pins;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic [31:0] rd;
        logic        irq;
        logic        io;
        logic [15:0] out;
        logic [15:0] oe;
    } exp_t;

    exp_t sbq[$];

    mmio_gpio_bank #(
        .WIDTH     (8),
        .NPORTS    (2),
        .BASE_ADDR (32'h800)
    ) dut (
        .clk      (clk),
        .resetE   (resetE),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .hit      (hit),
        .rdata    (rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
        end
    endtask

    // Monitor: every probed cycle consumes one expectation, sampled at negedge.
    always @(negedge clk) begin
        if (probe) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=empty expected=entry");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk(e.name, "hit",   {31'd0, hit}, {31'd0, e.hit});
                chk(e.name, "rdata", rdata,        e.rd);
                chk(e.name, "irq",   {31'd0, irq}, {31'd0, e.irq});
                if (e.io) begin
                    chk(e.name, "gpio_out", {16'd0, gpio_out}, {16'd0, e.out});
                    chk(e.name, "gpio_oe",  {16'd0, gpio_oe},  {16'd0, e.oe});
                end
            end
        end
    end

    task automatic op(input string name, input logic [31:0] a, input logic [31:0] wd,
                      input logic w, input logic r, input logic ehit,
                      input logic [31:0] erd, input logic eirq,
                      input logic io = 1'b0, input logic [15:0] eout = 16'h0,
                      input logic [15:0] eoe = 16'h0);
        exp_t e;
        @(posedge clk);
        #1;
        resetE  = rstv;
        gpio_in = pins;
        addr    = a;
        wdata   = wd;
        we      = w;
        re      = r;
        probe   = 1'b1;
        e.name = name; e.hit = ehit; e.rd = erd; e.irq = eirq;
        e.io = io; e.out = eout; e.oe = eoe;
        sbq.push_back(e);
    endtask

    task automatic rd(input string name, input logic [31:0] a,
                      input logic [31:0] erd, input logic eirq);
        op(name, a, 32'h0, 1'b0, 1'b1, 1'b1, erd, eirq);
    endtask

    task automatic wr(input string name, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] erd_before, input logic eirq);
        op(name, a, wd, 1'b1, 1'b0, 1'b1, erd_before, eirq);
    endtask

    initial begin
        resetE = 1'b0; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
        gpio_in = '0; probe = 1'b0; rstv = 1'b1; pins = 16'h0000;
        repeat (3) @(posedge clk);

        // reset state
        op("rst_out",  32'h800, 0, 0, 1, 1, 32'h0, 0, 1, 16'h0000, 16'h0000);
        rd("rst_dir1", 32'h824, 32'h0, 0);

        // DATA_OUT / DIR writes, rdata shows pre-write value during the write cycle
        op("wr_out0", 32'h800, 32'h5A, 1, 0, 1, 32'h0, 0, 1, 16'h0000, 16'h0000);
        op("wr_dir0", 32'h804, 32'hF0, 1, 0, 1, 32'h0, 0, 1, 16'h005A, 16'h0000);
        op("rd_out0", 32'h800, 0, 0, 1, 1, 32'h5A, 0, 1, 16'h005A, 16'h00F0);
        rd("rd_dir0", 32'h804, 32'hF0, 0);
        op("no_strb", 32'h800, 0, 0, 0, 0, 32'h0, 0);

        // input synchroniser latency and edge capture on port 1
        pins = 16'h8100;
        rd("din1_n0",  32'h828, 32'h00, 0);
        rd("din1_n1",  32'h828, 32'h00, 0);
        rd("din1_n2",  32'h828, 32'h81, 0);
        rd("edge1_n3", 32'h82C, 32'h81, 0);
        rd("din0_low", 32'h808, 32'h00, 0);

        // irq enable and W1C
        wr("ien1_wr",   32'h830, 32'h01, 32'h00, 0);
        rd("edge1_irq", 32'h82C, 32'h81, 1);
        wr("w1c_80",    32'h82C, 32'h80, 32'h81, 1);
        rd("edge1_01",  32'h82C, 32'h01, 1);
        wr("w1c_01",    32'h82C, 32'h01, 32'h01, 1);
        rd("edge1_clr", 32'h82C, 32'h00, 0);

        // falling edge is not captured
        pins = 16'h8000;
        rd("fall_din",  32'h828, 32'h81, 0);
        rd("fall_e1",   32'h82C, 32'h00, 0);
        rd("fall_e2",   32'h82C, 32'h00, 0);
        rd("fall_e3",   32'h82C, 32'h00, 0);

        // W1C coincident with a new rise on bit 0: set wins
        pins = 16'h8100;
        rd("race_m0",   32'h82C, 32'h00, 0);
        rd("race_m1",   32'h82C, 32'h00, 0);
        wr("race_w1c",  32'h82C, 32'h01, 32'h00, 0);
        rd("race_set",  32'h82C, 32'h01, 1);
        wr("race_clr",  32'h82C, 32'h01, 32'h01, 1);
        rd("race_zero", 32'h82C, 32'h00, 0);

        // port 0: DIR=F0 masks bit 7 edge, DATA_IN shows pin anyway
        pins = 16'h8181;
        rd("dir_d0",   32'h808, 32'h00, 0);
        rd("dir_d1",   32'h808, 32'h00, 0);
        rd("dir_d2",   32'h808, 32'h81, 0);
        rd("dir_edge", 32'h80C, 32'h01, 0);

        // unmapped accesses and read-only DATA_IN
        op("um_814", 32'h814, 32'hFF, 1, 0, 0, 32'h0, 0);
        op("um_840", 32'h840, 32'hFF, 1, 0, 0, 32'h0, 0);
        op("um_801", 32'h801, 32'hFF, 1, 0, 0, 32'h0, 0);
        op("um_81C", 32'h81C, 32'h0,  0, 1, 0, 32'h0, 0);
        rd("um_out1", 32'h820, 32'h00, 0);
        op("um_out0", 32'h800, 0, 0, 1, 1, 32'h5A, 0, 1, 16'h005A, 16'h00F0);
        rd("um_dir0", 32'h804, 32'hF0, 0);
        rd("um_ien0", 32'h810, 32'h00, 0);
        wr("din_wr",  32'h808, 32'h00, 32'h81, 0);
        rd("din_kept", 32'h808, 32'h81, 0);
        wr("ien1_hi", 32'h830, 32'hFFFFFF01, 32'h01, 0);
        rd("ien1_trunc", 32'h830, 32'h01, 0);

        // mid-run async reset with irq asserted
        wr("ien0_wr",  32'h810, 32'h01, 32'h00, 0);
        op("pre_rst",  32'h810, 0, 0, 1, 1, 32'h01, 1, 1, 16'h005A, 16'h00F0);
        rstv = 1'b0;
        op("in_rst",   32'h800, 0, 0, 1, 1, 32'h0, 0, 1, 16'h0000, 16'h0000);
        op("rst_wr",   32'h800, 32'h33, 1, 0, 1, 32'h0, 0, 1, 16'h0000, 16'h0000);
        rstv = 1'b1;
        op("post_rst", 32'h800, 0, 0, 1, 1, 32'h0, 0, 1, 16'h0000, 16'h0000);
        rd("post_out1", 32'h820, 32'h00, 0);
        rd("post_dir0", 32'h804, 32'h00, 0);

        @(posedge clk);
        #1;
        probe = 1'b0; we = 1'b0; re = 1'b0;
        repeat (2) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual=%0d expected=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
